// File: rtl/wb_pkg.sv
// Shared sizes, request type and register-map helpers for the register-file write-back path.
// Addresses 0..VEC_REG_LAST are vector registers; everything above is scalar/special.
package wb_pkg;
  localparam int LANE_W       = 8;
  localparam int VEC_SIZE     = 4;
  localparam int SEL_BITS     = 4;
  localparam int DEPTH        = 2;
  localparam int DATA_W       = VEC_SIZE * LANE_W;
  localparam int NUM_REGS     = 2 ** SEL_BITS;
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int VEC_REG_LAST = 3;
  localparam int SPECIAL_BASE = 12;

  typedef logic [SEL_BITS-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]   vec_data_t;

  typedef struct packed {
    reg_addr_t addr;
    vec_data_t data;
  } wb_req_t;

  function automatic logic is_vec_reg(input reg_addr_t addr);
    return addr <= reg_addr_t'(VEC_REG_LAST);
  endfunction

  function automatic logic is_special_reg(input reg_addr_t addr);
    return addr >= reg_addr_t'(SPECIAL_BASE);
  endfunction

  function automatic vec_data_t scalar_zext(input vec_data_t d);
    return {{(DATA_W-LANE_W){1'b0}}, d[LANE_W-1:0]};
  endfunction

  function automatic vec_data_t scalar_bcast(input vec_data_t d);
    return {VEC_SIZE{d[LANE_W-1:0]}};
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of wb_req_t; head is valid the cycle after the push edge.
// Backpressure: full refuses a push even in a popping cycle; per-entry valid/addr taps feed hazard tracking.
module wb_fifo
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_req_t               din,
  output logic                  full,
  output logic                  empty,
  input  logic                  pop,
  output wb_req_t               head,
  output logic [DEPTH-1:0]      ent_vld,
  output reg_addr_t [DEPTH-1:0] ent_addr
);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH;

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_MAX);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // A slot is occupied when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i]  = {1'b0, PTR_W'(i) - rd_ptr_q} < cnt_q;
      ent_addr[i] = mem_q[i].addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/reg_writeback.sv
// Buffers ALU (A) and load (B) results and writes one per cycle round-robin; strobe 1 cycle after pop.
// Backpressure: x_ready low only while that FIFO is full. WB_FWD_EN adds a lane-broadcast bypass copy.
module reg_writeback
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [SEL_BITS-1:0] a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [SEL_BITS-1:0] b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                regWrEnSc,
  output logic                regWrEnVec,
  output logic [SEL_BITS-1:0] regToWrite,
  output logic [DATA_W-1:0]   dataIn,
  output logic [NUM_REGS-1:0] pending
`ifdef WB_FWD_EN
  ,
  output logic                fwd_valid,
  output logic [SEL_BITS-1:0] fwd_addr,
  output logic [DATA_W-1:0]   fwd_data
`endif
);
  logic                  a_full, a_empty, b_full, b_empty;
  wb_req_t               a_req, b_req, a_head, b_head, sel_req;
  logic [DEPTH-1:0]      a_ent_vld, b_ent_vld;
  reg_addr_t [DEPTH-1:0] a_ent_addr, b_ent_addr;
  logic                  grant_a, grant_b;
  logic                  rr_q, rr_d;  // set when A won last, so B wins the next tie
  logic                  en_sc_q, en_sc_d, en_vec_q, en_vec_d;
  reg_addr_t             addr_q, addr_d;
  vec_data_t             data_q, data_d;

  assign a_req   = '{addr: a_addr, data: a_data};
  assign b_req   = '{addr: b_addr, data: b_data};
  assign a_ready = !a_full;
  assign b_ready = !b_full;

  wb_fifo u_fifo_a (
    .clk(clk), .rst(rst), .push(a_valid), .din(a_req), .full(a_full), .empty(a_empty),
    .pop(grant_a), .head(a_head), .ent_vld(a_ent_vld), .ent_addr(a_ent_addr)
  );

  wb_fifo u_fifo_b (
    .clk(clk), .rst(rst), .push(b_valid), .din(b_req), .full(b_full), .empty(b_empty),
    .pop(grant_b), .head(b_head), .ent_vld(b_ent_vld), .ent_addr(b_ent_addr)
  );

  always_comb begin
    grant_a  = !a_empty && (b_empty || !rr_q);
    grant_b  = !b_empty && !grant_a;
    sel_req  = grant_a ? a_head : b_head;
    rr_d     = rr_q;
    en_sc_d  = 1'b0;
    en_vec_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (grant_a || grant_b) begin
      rr_d     = grant_a;
      addr_d   = sel_req.addr;
      en_vec_d = is_vec_reg(sel_req.addr);
      en_sc_d  = !is_vec_reg(sel_req.addr);
      data_d   = is_vec_reg(sel_req.addr) ? sel_req.data : scalar_zext(sel_req.data);
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ent_vld[i]) pending[a_ent_addr[i]] = 1'b1;
      if (b_ent_vld[i]) pending[b_ent_addr[i]] = 1'b1;
    end
    if (en_sc_q || en_vec_q) pending[addr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= 1'b0;
      en_sc_q  <= 1'b0;
      en_vec_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      rr_q     <= rr_d;
      en_sc_q  <= en_sc_d;
      en_vec_q <= en_vec_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign regWrEnSc  = en_sc_q;
  assign regWrEnVec = en_vec_q;
  assign regToWrite = addr_q;
  assign dataIn     = data_q;

`ifdef WB_FWD_EN
  assign fwd_valid = en_sc_q || en_vec_q;
  assign fwd_addr  = addr_q;
  assign fwd_data  = en_vec_q ? data_q : scalar_bcast(data_q);
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: latency, register map, round-robin, full backpressure, reset flush.
// Bypass outputs are checked when WB_FWD_EN is defined.
module tb_reg_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [3:0]  a_addr, b_addr, regToWrite;
  logic [31:0] a_data, b_data, dataIn;
  logic        regWrEnSc, regWrEnVec;
  logic [15:0] pending;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .regWrEnSc(regWrEnSc), .regWrEnVec(regWrEnVec), .regToWrite(regToWrite),
    .dataIn(dataIn), .pending(pending)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic a_acc, b_acc;
    int   ai, bi, k;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;

    // Reset state
    do_reset;
    chk("rst_strobes", {regWrEnSc, regWrEnVec}, 2'b00);
    chk("rst_addr", regToWrite, 4'd0);
    chk("rst_data", dataIn, 32'h0);
    chk("rst_pending", pending, 16'h0);
    chk("rst_readies", {a_ready, b_ready}, 2'b11);

    // 1: scalar write from A
    a_valid = 1'b1; a_addr = 4'd4; a_data = 32'h05;
    tick;
    a_valid = 1'b0;
    chk("t1_pend_buf", pending, 16'h0010);
    chk("t1_no_strobe", {regWrEnSc, regWrEnVec}, 2'b00);
    tick;
    chk("t1_strobes", {regWrEnSc, regWrEnVec}, 2'b10);
    chk("t1_addr", regToWrite, 4'd4);
    chk("t1_data", dataIn, 32'h0000_0005);
    chk("t1_pend_wr", pending, 16'h0010);
    tick;
    chk("t1_strobe_off", {regWrEnSc, regWrEnVec}, 2'b00);
    chk("t1_pend_clr", pending, 16'h0);
    chk("t1_addr_hold", regToWrite, 4'd4);
    chk("t1_data_hold", dataIn, 32'h0000_0005);

    // 2: vector write from B
    b_valid = 1'b1; b_addr = 4'd3; b_data = 32'hDEAD_BEEF;
    tick;
    b_valid = 1'b0;
    tick;
    chk("t2_strobes", {regWrEnSc, regWrEnVec}, 2'b01);
    chk("t2_addr", regToWrite, 4'd3);
    chk("t2_data", dataIn, 32'hDEAD_BEEF);
    chk("t2_pend", pending, 16'h0008);
    tick;
    chk("t2_strobe_off", {regWrEnSc, regWrEnVec}, 2'b00);

    // 3: both sources streaming; writes alternate A,B starting with A
    do_reset;
    ai = 0; bi = 0;
    a_valid = 1'b1; a_addr = 4'd1; a_data = 32'hA5A5_0000;
    b_valid = 1'b1; b_addr = 4'd13; b_data = 32'h7700_00B0;
    a_acc = a_ready; b_acc = b_ready;
    for (int c = 0; c < 9; c++) begin
      tick;
      if (a_acc) ai++;
      if (b_acc) bi++;
      if (c > 0) begin
        k = c - 1;
        if (k % 2 == 0) begin
          chk("t3_strobe_a", {regWrEnSc, regWrEnVec}, 2'b01);
          chk("t3_addr_a", regToWrite, 4'd1);
          chk("t3_data_a", dataIn, 32'hA5A5_0000 + 32'(k / 2));
        end else begin
          chk("t3_strobe_b", {regWrEnSc, regWrEnVec}, 2'b10);
          chk("t3_addr_b", regToWrite, 4'd13);
          chk("t3_data_b", dataIn, 32'h0000_00B0 + 32'(k / 2));
        end
      end
      a_data = 32'hA5A5_0000 + 32'(ai);
      b_data = 32'h7700_00B0 + 32'(bi);
      a_acc = a_ready; b_acc = b_ready;
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // 4: A fills while B takes its turn; push into full A is dropped
    do_reset;
    a_valid = 1'b1; a_addr = 4'd2; a_data = 32'h1111_1100;
    b_valid = 1'b1; b_addr = 4'd5; b_data = 32'hCAFE_0051;
    tick;
    chk("t4_pend0", pending, 16'h0024);
    a_data = 32'h1111_1101; b_data = 32'hCAFE_0052;
    tick;
    chk("t4_w0_addr", regToWrite, 4'd2);
    chk("t4_w0_data", dataIn, 32'h1111_1100);
    a_data = 32'h1111_1102; b_valid = 1'b0;
    tick;
    chk("t4_w1_strobe", {regWrEnSc, regWrEnVec}, 2'b10);
    chk("t4_w1_data", dataIn, 32'h0000_0051);
    chk("t4_a_full", a_ready, 1'b0);
    chk("t4_pend_full", pending, 16'h0024);
    a_data = 32'h1111_1103;
    tick;
    a_valid = 1'b0;
    chk("t4_w2_data", dataIn, 32'h1111_1101);
    chk("t4_a_ready_back", a_ready, 1'b1);
    tick;
    chk("t4_w3_addr", regToWrite, 4'd5);
    chk("t4_w3_data", dataIn, 32'h0000_0052);
    tick;
    chk("t4_w4_data", dataIn, 32'h1111_1102);
    chk("t4_w4_strobe", {regWrEnSc, regWrEnVec}, 2'b01);
    for (int c = 0; c < 2; c++) begin
      tick;
      chk("t4_no_dropped_write", {regWrEnSc, regWrEnVec}, 2'b00);
    end
    chk("t4_pend_idle", pending, 16'h0);

    // 5: reset mid-operation with FIFOs loaded as far as arbitration allows
    do_reset;
    a_valid = 1'b1; a_addr = 4'd7; a_data = 32'h0000_0707;
    b_valid = 1'b1; b_addr = 4'd9; b_data = 32'h0000_0909;
    tick;
    tick;
    tick;
    chk("t5_pend_loaded", pending, 16'h0280);
    chk("t5_a_full", a_ready, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    chk("t5_pend", pending, 16'h0);
    chk("t5_strobes", {regWrEnSc, regWrEnVec}, 2'b00);
    chk("t5_readies", {a_ready, b_ready}, 2'b11);
    chk("t5_addr", regToWrite, 4'd0);
    chk("t5_data", dataIn, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("t5_no_stale", {regWrEnSc, regWrEnVec, pending}, 18'h0);
    end

`ifdef WB_FWD_EN
    // 6: bypass copy of a scalar write is lane-broadcast
    a_valid = 1'b1; a_addr = 4'd14; a_data = 32'h09;
    tick;
    a_valid = 1'b0;
    chk("t6_fwd_idle", fwd_valid, 1'b0);
    tick;
    chk("t6_strobe", regWrEnSc, 1'b1);
    chk("t6_fwd_valid", fwd_valid, 1'b1);
    chk("t6_fwd_addr", fwd_addr, 4'd14);
    chk("t6_fwd_data", fwd_data, 32'h0909_0909);
    chk("t6_data", dataIn, 32'h0000_0009);
    tick;
    chk("t6_fwd_off", fwd_valid, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
